// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int FRAME_DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: free-runs 0..2N-1, flags the half-bit and full-bit points.
// Clearing forces the count back to 0 so every state entry starts a fresh bit period.
module uart_baud_cnt #(
  parameter int N = 30
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);
  localparam int W = $clog2(2 * N);
  localparam logic [W-1:0] HALF_LAST = W'(N - 1);
  localparam logic [W-1:0] FULL_LAST = W'(2 * N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear || (cnt_q == FULL_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick = (cnt_q == HALF_LAST);
  assign full_tick = (cnt_q == FULL_LAST);
endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rxd, samples mid-bit, presents each byte with a
// one-cycle rdata_ready pulse (or a one-cycle ferr pulse on a bad stop bit).
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 30
) (
  output logic [7:0] rdata,
  output logic       rdata_ready,
  output logic       ferr,
  input  logic       rxd,
  input  logic       clk,
  input  logic       rstn
);
  import uart_pkg::*;

  logic [1:0] sync_q;
  logic       rxs;
  rx_state_t  state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rdy_q, rdy_d;
  logic       ferr_q, ferr_d;
  logic       cnt_clear;
  logic       half_tick, full_tick;

  assign rxs = sync_q[1];

  uart_baud_cnt #(.N(CLK_PER_HALF_BIT)) u_baud (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (cnt_clear),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    rdy_d     = 1'b0;
    ferr_d    = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (!rxs) begin
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (half_tick) begin
          cnt_clear = 1'b1;
          idx_d     = '0;
          state_d   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_tick) begin
          cnt_clear       = 1'b1;
          shift_d[idx_q]  = rxs;
          if (idx_q == 3'(FRAME_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a zero-gap start bit be caught.
        if (full_tick) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
          if (rxs) begin
            rdata_d = shift_q;
            rdy_d   = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_ready = rdy_q;
  assign ferr        = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, glitch/reset corner cases, then a random byte stream
// checked against a frame-level model (value, kind and exact latency of each output pulse).
module tb_uart_rx;
  localparam int N = 30;
  localparam int BIT = 2 * N;
  localparam int LAT = 19 * N + 3;

  logic [7:0] rdata;
  logic       rdata_ready, ferr, rxd, clk, rstn;

  uart_rx #(.CLK_PER_HALF_BIT(N)) dut (
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr),
    .rxd         (rxd),
    .clk         (clk),
    .rstn        (rstn)
  );

  typedef struct {
    bit         is_ferr;
    logic [7:0] dat;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] dat;
    bit         stop;
    int         gap;
    bit         exp_ferr;
    logic [7:0] exp_rdata;
  } vec_t;

  ev_t  evq[$];
  vec_t tbl[6];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every output pulse as an event; both outputs high together is a fault.
  always @(negedge clk) begin
    if (rdata_ready || ferr) begin
      total++;
      if (rdata_ready && ferr) begin
        bad++;
        $display("FAIL both_pulses: ready=%0b ferr=%0b at cycle %0d, required not both", rdata_ready, ferr, cyc);
      end
      if (rdata_ready) evq.push_back('{1'b0, rdata, cyc});
      if (ferr)        evq.push_back('{1'b1, rdata, cyc});
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the stop bit and idle gap.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int gap, output int t_fall);
    rxd = 1'b0;
    t_fall = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (gap * BIT) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input bit exp_ferr, input logic [7:0] exp_dat,
                             input int t_fall, input logic [7:0] exp_rdata);
    ev_t ev;
    chk({nm, "_pulses"}, evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      chk({nm, "_is_ferr"}, int'(ev.is_ferr), int'(exp_ferr));
      if (!exp_ferr) chk({nm, "_data"}, int'(ev.dat), int'(exp_dat));
      chk({nm, "_latency"}, ev.cyc - t_fall, LAT);
    end
    evq.delete();
    chk({nm, "_rdata_held"}, int'(rdata), int'(exp_rdata));
  endtask

  initial begin
    int         t_fall;
    logic [7:0] model_rdata;
    logic [7:0] b;
    bit         stop;
    int         gap;

    tbl[0] = '{8'hAA, 1'b1, 2, 1'b0, 8'hAA};
    tbl[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
    tbl[3] = '{8'h5A, 1'b1, 2, 1'b0, 8'h5A};
    tbl[4] = '{8'h3C, 1'b0, 2, 1'b1, 8'h5A};
    tbl[5] = '{8'h11, 1'b1, 1, 1'b0, 8'h11};

    rstn = 1'b0;
    rxd  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rdata", int'(rdata), 0);
    chk("reset_ready", int'(rdata_ready), 0);
    chk("reset_ferr", int'(ferr), 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].dat, tbl[i].stop, tbl[i].gap, t_fall);
      check_frame($sformatf("vec%0d", i), tbl[i].exp_ferr, tbl[i].dat, t_fall, tbl[i].exp_rdata);
    end
    model_rdata = 8'h11;

    // Short low pulse must be rejected as a glitch.
    rxd = 1'b0;
    repeat (N / 2) @(negedge clk);
    rxd = 1'b1;
    repeat (25 * N) @(negedge clk);
    chk("glitch_pulses", evq.size(), 0);
    chk("glitch_rdata", int'(rdata), int'(model_rdata));
    evq.delete();
    send_frame(8'h7E, 1'b1, 1, t_fall);
    check_frame("after_glitch", 1'b0, 8'h7E, t_fall, 8'h7E);

    // Reset after data bit 3 of 0xC3.
    b = 8'hC3;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rstn = 1'b0;
    #1;
    chk("midreset_rdata", int'(rdata), 0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (25 * N) @(negedge clk);
    chk("midreset_pulses", evq.size(), 0);
    evq.delete();
    send_frame(8'hC3, 1'b1, 1, t_fall);
    check_frame("after_reset", 1'b0, 8'hC3, t_fall, 8'hC3);
    model_rdata = 8'hC3;

    // Random stream with occasional framing errors and random idle gaps.
    for (int i = 0; i < 40; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = $urandom_range(0, 5);
      if (!stop && gap == 0) gap = 1;
      send_frame(b, stop, gap, t_fall);
      if (stop) model_rdata = b;
      check_frame($sformatf("rnd%0d", i), !stop, b, t_fall, model_rdata);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
